codebreaker_parallel: RTL

Parametrised key-search controller, successor to the single-lane codebreaker. It sweeps a programmable key range across LANES decrypt cores in lockstep and tests each lane's output against a selectable character set. It hands the first hit to the text renderer, and can resume the search after a hit. It sits between the board top level (start button, stopwatch, LEDs, renderer) and LANES external decrypt cores, so the cores can be modelled behaviourally in test.

---
 rtl/codebreaker_parallel.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/codebreaker_parallel.sv
// codebreaker_parallel: sweeps a key range across LANES decrypt cores in
// lockstep, tests each lane's plaintext against a charset and reports the first hit.
// Ports: clk/reset (async active-low); start/resume/charset_mode/key_start/key_end;
// renderer handshake (draw_plaintext, done_drawing_plaintext, plaintext_to_draw);
// per-lane core bus (dec_enable, dec_key, dec_done, dec_text);
// status (stopwatch_run, found, exhausted, found_key, key_display).
module codebreaker_parallel #(
  parameter int KEY_WIDTH  = 24,
  parameter int LANES      = 4,
  parameter int TEXT_BYTES = 16,
  parameter int DISP_BITS  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              resume,
  input  logic                              charset_mode,
  input  logic [KEY_WIDTH-1:0]              key_start,
  input  logic [KEY_WIDTH-1:0]              key_end,
  input  logic                              done_drawing_plaintext,
  input  logic [LANES-1:0]                  dec_done,
  input  logic [LANES*8*TEXT_BYTES-1:0]     dec_text,
  output logic [LANES-1:0]                  dec_enable,
  output logic [LANES*KEY_WIDTH-1:0]        dec_key,
  output logic                              stopwatch_run,
  output logic                              draw_plaintext,
  output logic                              found,
  output logic                              exhausted,
  output logic [KEY_WIDTH-1:0]              found_key,
  output logic [8*TEXT_BYTES-1:0]           plaintext_to_draw,
  output logic [DISP_BITS-1:0]              key_display
);

  localparam int KW1 = KEY_WIDTH + 1;
  localparam int TW  = 8 * TEXT_BYTES;

  typedef enum logic [2:0] {
    IDLE, DECR, CHECK, DISP, FOUND, EXHAUSTED
  } state_t;

  state_t state, state_d;

  // one extra bit so the sweep can step past all-ones without wrapping
  logic [KEY_WIDTH:0] base;
  logic [KEY_WIDTH:0] kend;
  logic               mode;

  logic [KEY_WIDTH:0] lane_key [LANES];
  logic [KEY_WIDTH:0] next_base;
  logic [LANES-1:0]   active;
  logic [LANES-1:0]   hit;
  logic               all_done;
  logic               any_hit;
  logic [KEY_WIDTH-1:0] win_key;
  logic [TW-1:0]        win_text;
  logic               can_start;

  function automatic logic in_set(input logic [7:0] c, input logic m);
    if (m)
      return (c >= 8'h20) && (c <= 8'h7E);
    return (c == 8'h20) ||
           ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h5A));
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_key[i] = base + KW1'(i);
      active[i]   = lane_key[i] <= kend;
      hit[i]      = active[i];
      for (int b = 0; b < TEXT_BYTES; b++)
        if (!in_set(dec_text[i*TW + b*8 +: 8], mode))
          hit[i] = 1'b0;
    end
  end

  // walk down so the lowest-index hit lane wins
  always_comb begin
    win_key  = '0;
    win_text = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (hit[i]) begin
        win_key  = lane_key[i][KEY_WIDTH-1:0];
        win_text = dec_text[i*TW +: TW];
      end
  end

  assign any_hit   = |hit;
  assign all_done  = &(dec_done | ~active);
  assign next_base = base + KW1'(LANES);
  assign can_start = start &&
    (state == IDLE || state == FOUND || state == EXHAUSTED);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, EXHAUSTED: begin
        if (start) begin
          if (key_start > key_end) state_d = EXHAUSTED;
          else                     state_d = DECR;
        end
      end
      DECR: begin
        if (all_done) state_d = CHECK;
      end
      CHECK: begin
        if (any_hit)               state_d = DISP;
        else if (next_base > kend) state_d = EXHAUSTED;
        else                       state_d = DECR;
      end
      DISP: begin
        if (done_drawing_plaintext) state_d = FOUND;
      end
      FOUND: begin
        if (start) begin
          if (key_start > key_end) state_d = EXHAUSTED;
          else                     state_d = DECR;
        end else if (resume) begin
          if (found_key == kend[KEY_WIDTH-1:0]) state_d = EXHAUSTED;
          else                                   state_d = DECR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      base              <= '0;
      kend              <= '0;
      mode              <= 1'b0;
      found_key         <= '0;
      plaintext_to_draw <= '0;
    end else begin
      state <= state_d;
      if (can_start) begin
        base <= {1'b0, key_start};
        kend <= {1'b0, key_end};
        mode <= charset_mode;
      end else if (state == FOUND && resume &&
                   found_key != kend[KEY_WIDTH-1:0]) begin
        base <= {1'b0, found_key} + KW1'(1);
      end else if (state == CHECK) begin
        if (any_hit) begin
          found_key         <= win_key;
          plaintext_to_draw <= win_text;
        end else if (next_base <= kend) begin
          base <= next_base;
        end
      end
    end
  end

  always_comb begin
    dec_enable = (state == DECR) ? active : '0;
    for (int i = 0; i < LANES; i++)
      dec_key[i*KEY_WIDTH +: KEY_WIDTH] =
        (state == DECR) ? lane_key[i][KEY_WIDTH-1:0] : '0;
  end

  assign stopwatch_run  = (state == DECR) || (state == CHECK) ||
                          (state == DISP);
  assign draw_plaintext = (state == DISP);
  assign found          = (state == FOUND);
  assign exhausted      = (state == EXHAUSTED);
  assign key_display    = (state == DISP || state == FOUND) ?
                          found_key[KEY_WIDTH-1 -: DISP_BITS] :
                          base[KEY_WIDTH-1 -: DISP_BITS];

endmodule
